// File: rtl/multicycle_cu_if.sv
// Control-unit bus: instruction fields and memory handshake coming in,
// datapath controls, strobes and status going out.
interface multicycle_cu_if;
    logic [6:0] Opcode;
    logic [2:0] Function3;
    logic [6:0] Function7;
    logic       MemReady;
    logic       MemReq;
    logic       MemIsData;
    logic       IRWr;
    logic       PCWr;
    logic [2:0] ImmSrc;
    logic       ALUASrc;
    logic       ALUBSrc;
    logic       RUWr;
    logic [4:0] BrOp;
    logic [3:0] ALUOp;
    logic       DMWr;
    logic [2:0] DMCtrl;
    logic [1:0] RUDataWrSrc;
    logic [2:0] State;
    logic       Illegal;
    logic       Timeout;

    // The control unit drives the controls and reads the instruction/handshake.
    modport master (
        input  Opcode, Function3, Function7, MemReady,
        output MemReq, MemIsData, IRWr, PCWr, ImmSrc, ALUASrc, ALUBSrc, RUWr,
               BrOp, ALUOp, DMWr, DMCtrl, RUDataWrSrc, State, Illegal, Timeout
    );

    // The datapath/memory side sees the mirror image.
    modport slave (
        output Opcode, Function3, Function7, MemReady,
        input  MemReq, MemIsData, IRWr, PCWr, ImmSrc, ALUASrc, ALUBSrc, RUWr,
               BrOp, ALUOp, DMWr, DMCtrl, RUDataWrSrc, State, Illegal, Timeout
    );
endinterface

// File: rtl/multicycle_cu.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// datapath control decode, and a memory-request watchdog that halts the core.
module multicycle_cu #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit TIMEOUT_EN  = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    multicycle_cu_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Last count value at which a still-waiting request is given up.
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_next;
    logic       illegal, timeout, illegal_set, timeout_set;
    logic [7:0] wait_cnt;
    logic       waiting, expired;

    logic       is_legal, is_load, is_store, is_branch;
    logic [2:0] imm_src, dm_ctrl;
    logic       alu_a_src, alu_b_src;
    logic [4:0] br_op;
    logic [3:0] alu_op;
    logic [1:0] ru_src;

    logic mem_req, mem_is_data, ir_wr, pc_wr, ru_wr, dm_wr, fields_en;

    // Only Function7[5] is meaningful to this decoder.
    logic unused_f7;
    assign unused_f7 = ^{bus.Function7[6], bus.Function7[4:0]};

    assign is_load   = (bus.Opcode == OP_LOAD);
    assign is_store  = (bus.Opcode == OP_STORE);
    assign is_branch = (bus.Opcode == OP_BR);

    // A request is waiting whenever memory is asked and has not answered.
    assign waiting = (state == FETCH || state == MEM) && !bus.MemReady;
    assign expired = TIMEOUT_EN && waiting && (wait_cnt == LIMIT);

    // Datapath control decode of the current opcode.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        is_legal  = 1'b1;
        imm_src   = 3'b000;
        alu_a_src = 1'b0;
        alu_b_src = 1'b1;
        br_op     = 5'b00000;
        alu_op    = 4'b0000;
        dm_ctrl   = 3'b000;
        ru_src    = 2'b00;
        case (bus.Opcode)
            OP_R:     begin
                alu_b_src = 1'b0;
                alu_op    = {bus.Function7[5], bus.Function3};
            end
            OP_I:     alu_op = {(bus.Function3 == 3'b101) ? bus.Function7[5] : 1'b0,
                                bus.Function3};
            OP_LOAD:  begin
                dm_ctrl = bus.Function3;
                ru_src  = 2'b01;
            end
            OP_STORE: begin
                imm_src = 3'b001;
                dm_ctrl = bus.Function3;
            end
            OP_BR:    begin
                imm_src   = 3'b101;
                alu_a_src = 1'b1;
                br_op     = {2'b01, bus.Function3};
            end
            OP_JAL:   begin
                imm_src   = 3'b110;
                alu_a_src = 1'b1;
                br_op     = 5'b10000;
                ru_src    = 2'b10;
            end
            OP_JALR:  begin
                br_op  = 5'b10000;
                ru_src = 2'b10;
            end
            OP_LUI:   begin
                imm_src = 3'b010;
                alu_op  = 4'b1111;
            end
            OP_AUIPC: begin
                imm_src   = 3'b010;
                alu_a_src = 1'b1;
            end
            default:  is_legal = 1'b0;
        endcase
    end

    // Next-state and per-state strobe generation.
    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_is_data = 1'b0;
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        ru_wr       = 1'b0;
        dm_wr       = 1'b0;
        fields_en   = 1'b0;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (bus.MemReady) begin
                    ir_wr      = 1'b1;
                    state_next = DECODE;
                end else if (expired) begin
                    timeout_set = 1'b1;
                    state_next  = HALT;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    state_next = EXECUTE;
                end else begin
                    illegal_set = 1'b1;
                    state_next  = HALT;
                end
            end
            EXECUTE: begin
                fields_en = 1'b1;
                if (is_load || is_store) begin
                    state_next = MEM;
                end else if (is_branch) begin
                    pc_wr      = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                fields_en   = 1'b1;
                mem_req     = 1'b1;
                mem_is_data = 1'b1;
                dm_wr       = is_store;
                if (bus.MemReady) begin
                    pc_wr      = is_store;
                    state_next = is_store ? FETCH : WB;
                end else if (expired) begin
                    timeout_set = 1'b1;
                    state_next  = HALT;
                end
            end
            WB: begin
                fields_en  = 1'b1;
                ru_wr      = 1'b1;
                pc_wr      = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // the pre-edge values of the others.
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            illegal <= illegal | illegal_set;
            timeout <= timeout | timeout_set;
        end
    end

    // Memory wait counter: restarts on each new request phase.
    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state_next != state && (state_next == FETCH || state_next == MEM))
            wait_cnt <= '0;
        else if (waiting)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Strobes are suppressed while reset is held so an aborted instruction
    // never commits anything in its final cycle.
    assign bus.MemReq      = mem_req;
    assign bus.MemIsData   = mem_is_data;
    assign bus.IRWr        = ir_wr & rst_n;
    assign bus.PCWr        = pc_wr & rst_n;
    assign bus.RUWr        = ru_wr & rst_n;
    assign bus.DMWr        = dm_wr & rst_n;
    assign bus.ImmSrc      = fields_en ? imm_src   : 3'b000;
    assign bus.ALUASrc     = fields_en ? alu_a_src : 1'b0;
    assign bus.ALUBSrc     = fields_en ? alu_b_src : 1'b0;
    assign bus.BrOp        = fields_en ? br_op     : 5'b00000;
    assign bus.ALUOp       = fields_en ? alu_op    : 4'b0000;
    assign bus.DMCtrl      = fields_en ? dm_ctrl   : 3'b000;
    assign bus.RUDataWrSrc = fields_en ? ru_src    : 2'b00;
    assign bus.State       = state;
    assign bus.Illegal     = illegal;
    assign bus.Timeout     = timeout;
endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: per-cycle expected outputs are queued as
// each instruction's stimulus is planned, then popped and compared cycle by cycle.
module tb_multicycle_cu;
    logic clk = 1'b0;
    logic rst_n;

    multicycle_cu_if bus ();

    multicycle_cu #(.MEM_TIMEOUT(4), .TIMEOUT_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, misd, irwr, pcwr, ruwr, dmwr;
        logic [2:0] imm;
        logic       asrc, bsrc;
        logic [4:0] br;
        logic [3:0] aluop;
        logic [2:0] dmc;
        logic [1:0] rusrc;
        logic       ill, to;
    } obs_t;

    typedef struct {
        logic ready;
        logic rst;
        obs_t e;
    } step_t;

    step_t      sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic       exp_ill, exp_to;

    // Reference behaviour written from the instruction-class tables.
    function automatic obs_t model(input logic [2:0] st, input logic ready, input logic rst);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.ill = exp_ill;
        o.to  = exp_to;
        case (st)
            3'd0: begin o.mreq = 1'b1; o.irwr = ready; end
            3'd2: o.pcwr = (cur_op == 7'b1100011);
            3'd3: begin
                o.mreq = 1'b1;
                o.misd = 1'b1;
                o.dmwr = (cur_op == 7'b0100011);
                o.pcwr = (cur_op == 7'b0100011) && ready;
            end
            3'd4: begin o.ruwr = 1'b1; o.pcwr = 1'b1; end
            default: ;
        endcase
        if (st == 3'd2 || st == 3'd3 || st == 3'd4) begin
            o.bsrc = 1'b1;
            case (cur_op)
                7'b0110011: begin o.bsrc = 1'b0; o.aluop = {cur_f7[5], cur_f3}; end
                7'b0010011: o.aluop = {(cur_f3 == 3'b101) && cur_f7[5], cur_f3};
                7'b0000011: begin o.dmc = cur_f3; o.rusrc = 2'b01; end
                7'b0100011: begin o.imm = 3'b001; o.dmc = cur_f3; end
                7'b1100011: begin o.imm = 3'b101; o.asrc = 1'b1; o.br = {2'b01, cur_f3}; end
                7'b1101111: begin o.imm = 3'b110; o.asrc = 1'b1; o.br = 5'b10000; o.rusrc = 2'b10; end
                7'b1100111: begin o.br = 5'b10000; o.rusrc = 2'b10; end
                7'b0110111: begin o.imm = 3'b010; o.aluop = 4'b1111; end
                7'b0010111: begin o.imm = 3'b010; o.asrc = 1'b1; end
                default: ;
            endcase
        end
        if (!rst) begin
            o.irwr = 1'b0; o.pcwr = 1'b0; o.ruwr = 1'b0; o.dmwr = 1'b0;
        end
        return o;
    endfunction

    function automatic obs_t sample();
        return {bus.State, bus.MemReq, bus.MemIsData, bus.IRWr, bus.PCWr, bus.RUWr,
                bus.DMWr, bus.ImmSrc, bus.ALUASrc, bus.ALUBSrc, bus.BrOp, bus.ALUOp,
                bus.DMCtrl, bus.RUDataWrSrc, bus.Illegal, bus.Timeout};
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
        bus.Opcode = op; bus.Function3 = f3; bus.Function7 = f7;
    endtask

    task automatic push(input logic [2:0] st, input logic ready, input logic rst = 1'b1);
        step_t s;
        s.ready = ready;
        s.rst   = rst;
        s.e     = model(st, ready, rst);
        sb.push_back(s);
    endtask

    // Apply each queued cycle and compare mid-cycle against its expectation.
    task automatic drain(input string tag);
        step_t s;
        obs_t  g;
        int    idx = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            bus.MemReady = s.ready;
            rst_n        = s.rst;
            @(negedge clk);
            g = sample();
            checks++;
            assert (g === s.e) else begin
                failures++;
                $error("FAIL %s step %0d: observed %h expected %h", tag, idx, g, s.e);
            end
            idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic plain(input string tag);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd4, 1'b0);
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        rst_n   = 1'b0;
        bus.MemReady = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        @(posedge clk);
        #1;

        // Reset held: FETCH, everything but MemReq low.
        push(3'd0, 1'b1, 1'b0);
        drain("reset");

        plain("add");
        set_instr(7'b0110011, 3'b000, 7'b0100000); plain("sub");
        set_instr(7'b0010011, 3'b101, 7'b0100000); plain("srai");
        set_instr(7'b0010011, 3'b110, 7'b0100000); plain("ori");
        set_instr(7'b0110111, 3'b000, 7'b0000000); plain("lui");
        set_instr(7'b0010111, 3'b000, 7'b0000000); plain("auipc");
        set_instr(7'b1101111, 3'b000, 7'b0000000); plain("jal");
        set_instr(7'b1100111, 3'b000, 7'b0000000); plain("jalr");

        // Store with three wait cycles; MemReady lands exactly at the limit.
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0);
        push(3'd3, 1'b0); push(3'd3, 1'b0); push(3'd3, 1'b0); push(3'd3, 1'b1);
        drain("sw");

        set_instr(7'b1100011, 3'b000, 7'b0000000);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0);
        drain("beq");
        set_instr(7'b1100011, 3'b001, 7'b0000000);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0);
        drain("bne");

        // Load aborted by reset in MEM, then a clean load.
        set_instr(7'b0000011, 3'b100, 7'b0000000);
        push(3'd0, 1'b0); push(3'd0, 1'b0); push(3'd0, 1'b1); push(3'd1, 1'b0);
        push(3'd2, 1'b0); push(3'd3, 1'b0); push(3'd3, 1'b0, 1'b0);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd3, 1'b1);
        push(3'd4, 1'b0);
        drain("lw_reset");

        // Reset in MEM of a store with MemReady high: no DMWr/PCWr.
        set_instr(7'b0100011, 3'b000, 7'b0000000);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd3, 1'b1, 1'b0);
        drain("sb_reset");

        // Reset in WB: no RUWr/PCWr.
        set_instr(7'b0110011, 3'b111, 7'b0000000);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd4, 1'b0, 1'b0);
        drain("and_reset");

        // Fetch answered on the fourth waiting cycle: success.
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        push(3'd0, 1'b0); push(3'd0, 1'b0); push(3'd0, 1'b0); push(3'd0, 1'b1);
        push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd4, 1'b0);
        drain("fetch_late");

        // Fetch never answered: HALT after four waiting cycles.
        push(3'd0, 1'b0); push(3'd0, 1'b0); push(3'd0, 1'b0); push(3'd0, 1'b0);
        exp_to = 1'b1;
        push(3'd5, 1'b0); push(3'd5, 1'b1); push(3'd5, 1'b0); push(3'd5, 1'b0, 1'b0);
        exp_to = 1'b0;
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd4, 1'b0);
        drain("fetch_timeout");

        // Load whose data access never completes.
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        push(3'd0, 1'b1); push(3'd1, 1'b0); push(3'd2, 1'b0);
        push(3'd3, 1'b0); push(3'd3, 1'b0); push(3'd3, 1'b0); push(3'd3, 1'b0);
        exp_to = 1'b1;
        push(3'd5, 1'b1); push(3'd5, 1'b0, 1'b0);
        exp_to = 1'b0;
        push(3'd0, 1'b0);
        drain("mem_timeout");

        // Unsupported opcode: HALT frozen for ten cycles, then reset.
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        push(3'd0, 1'b1); push(3'd1, 1'b0);
        exp_ill = 1'b1;
        for (int i = 0; i < 10; i++) push(3'd5, 1'(i % 2));
        push(3'd5, 1'b0, 1'b0);
        exp_ill = 1'b0;
        push(3'd0, 1'b0);
        drain("illegal");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, is the number of consecutive MemReady-low request cycles tolerated before a timeout; legal range is 2..255.
REQ-002 Parameter TIMEOUT_EN, default 1; when set to 0, the timeout logic is removed and requests wait indefinitely.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 Opcode  in  7  instruction-register bits [6:0], stable from DECODE through WB.
REQ-006 Function3  in  3  instruction bits [14:12].
REQ-007 Function7  in  7  instruction bits [31:25].
REQ-008 MemReady  in  1  memory completion handshake for the current request.
REQ-009 MemReq  out  1  memory request, held until MemReady.
REQ-010 MemIsData  out  1  0 = instruction fetch, 1 = data access.
REQ-011 IRWr  out  1  instruction-register load strobe.
REQ-012 PCWr  out  1  PC update strobe; the next-PC value comes from the datapath using BrOp.
REQ-013 ImmSrc 3, ALUASrc 1, ALUBSrc 1, RUWr 1, BrOp 5, ALUOp 4, DMWr 1, DMCtrl 3, RUDataWrSrc 2  out  datapath controls (see REQ-020..026).
REQ-014 State  out  3  current state encoding, for debug.
REQ-015 Illegal  out  1  sticky flag: unsupported opcode decoded.
REQ-016 Timeout  out  1  sticky flag: memory request timed out.

Function
REQ-017 State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 are unreachable and return to FETCH on the next clock.
REQ-018 FETCH: MemReq=1, MemIsData=0. When MemReady=1, pulse IRWr for that cycle and move to DECODE; otherwise stay in FETCH.
REQ-019 DECODE always lasts one cycle.
  - An opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} goes to HALT and sets Illegal.
  - Every other opcode goes to EXECUTE.
REQ-020 EXECUTE transitions:
  - Load or store goes to MEM.
  - Branch pulses PCWr and goes to FETCH.
  - Every other opcode goes to WB.
REQ-021 MEM: MemReq=1, MemIsData=1; DMWr=1 for stores only. When MemReady=1:
  - a store pulses PCWr and goes to FETCH;
  - a load goes to WB.
REQ-022 WB pulses RUWr and PCWr for one cycle, then goes to FETCH.
REQ-023 HALT holds until reset.
  - All strobes are 0 and MemReq=0.
  - Illegal and Timeout hold their values.
REQ-024 RUWr is asserted only in WB, DMWr only in MEM, IRWr only in FETCH. PCWr is asserted at most once per instruction.
REQ-025 ImmSrc encoding: I-type/load/jalr=000, S=001, U=010, B=101, J=110.
REQ-026 ALUASrc=1 (PC) for branch, jal and auipc; 0 otherwise. ALUBSrc=0 for R-type only; 1 otherwise.
REQ-027 ALUOp encoding:
  - R-type: {Function7[5], Function3}.
  - I-arith: {Function3==101 ? Function7[5] : 0, Function3}.
  - lui: 1111 (pass operand B).
  - All others: 0000 (add).
REQ-028 BrOp encoding: branch = {2'b01, Function3}; jal/jalr = 1xxxx with the low bits 0; otherwise 00000.
REQ-029 DMCtrl=Function3 for load/store. RUDataWrSrc: 01 for load, 10 for jal/jalr, 00 otherwise.
REQ-030 In FETCH, DECODE and HALT, all fields listed in REQ-013 are 0. In EXECUTE, MEM and WB they reflect the decode of the current opcode.
REQ-031 Timeout counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle MemReq=1 and MemReady=0.
  - On reaching MEM_TIMEOUT with MemReady still 0 (TIMEOUT_EN=1): go to HALT, set Timeout, drop MemReq the next cycle.
  - MemReady=1 in the same cycle the count reaches MEM_TIMEOUT counts as success.

Reset
REQ-032 While rst_n=0 at a clock edge, the block goes to FETCH and clears Illegal, Timeout and the counter. All outputs except MemReq are 0; MemReq=1 on the first cycle after release.
REQ-033 Reset asserted in any state, including mid-MEM and HALT, aborts the instruction with no RUWr, DMWr or PCWr pulse.

Verification
REQ-034 add (0110011, F3=000, F7=0000000), MemReady=1 immediately → states 0,1,2,4,0; RUWr=1 and PCWr=1 only in WB; ALUOp=0000, ALUBSrc=0.
REQ-035 sw (0100011, F3=010), MemReady delayed 3 cycles in MEM → DMWr=1 and MemReq=1 for 4 cycles, DMCtrl=010, ImmSrc=001, then PCWr pulse and return to FETCH; RUWr never asserted.
REQ-036 beq (1100011, F3=000) → EXECUTE shows BrOp=01000, ImmSrc=101, ALUASrc=1, PCWr=1, next state FETCH; total 3 cycles.
REQ-037 Opcode 1111111 → DECODE then HALT, Illegal=1, State=5; outputs frozen for 10 cycles; rst_n=0 for 1 cycle clears everything and State=0.
REQ-038 MEM_TIMEOUT=4, MemReady held 0 in FETCH → HALT after 4 waiting cycles, Timeout=1, MemReq=0 after that. Repeat with MemReady=1 on cycle 4 → DECODE and Timeout=0.
REQ-039 lw (0000011, F3=100) with rst_n pulsed low during MEM → FETCH on the next cycle, no RUWr pulse; a following lw completes as 0,1,2,3,4 with RUDataWrSrc=01.
